spi_reg_target: RTL and testbench

- 3-wire, half-duplex SPI target holding a small 8-bit register bank. It is the far end of our AXI-lite SPI master, used to model and verify that master and to act as a soft config-register slave in FPGA-to-FPGA links.
- SPI pins are oversampled on the system clock, so there is no SPI-clock domain.
- Each transaction is a command byte {rw, addr[6:0]} followed by one or more data bytes. The address auto-increments per byte while CS stays low.

---
 rtl/spi_reg_target.sv | 153 +++++++++++++++
 tb/tb_spi_reg_target.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_target.sv
// 3-wire SPI target with a small 8-bit register bank; SPI pins are oversampled on aclk.
// Transactions are {rw, addr[6:0]} then data bytes, with the address advancing per byte.
module spi_reg_target #(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  spi_clk,
  input  logic                  spi_cs_b,
  input  logic                  spi_data_i,
  output logic                  spi_data_o,
  output logic                  spi_data_t,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  reg_wr_stb,
  output logic [6:0]            reg_wr_addr,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_t;

  state_t                     r_state;
  logic                       r_clk_s1, r_clk_s2, r_clk_s3;
  logic                       r_cs_s1, r_cs_s2;
  logic                       r_din_s1, r_din_s2;
  logic [3:0]                 r_bcnt;
  logic [6:0]                 r_shift_in;
  logic [7:0]                 r_shift_out;
  logic [6:0]                 r_addr;
  logic [NUM_REGS-1:1][7:0]   r_bank;

  logic       w_rise, w_fall, w_wr_hit;
  logic [7:0] w_byte, w_cmd_rd, w_next_rd;
  logic [6:0] w_addr_next;

  // Register 0 is the constant ID; unmapped addresses read as zero.
  function automatic logic [7:0] rd_reg(input logic [6:0] a,
                                        input logic [NUM_REGS-1:1][7:0] bank);
    logic [7:0] v;
    v = (a == 7'd0) ? ID_VALUE : 8'h00;
    for (int i = 1; i < NUM_REGS; i++)
      if (a == 7'(i)) v = bank[i];
    return v;
  endfunction

  assign w_rise      = r_clk_s2 & ~r_clk_s3;
  assign w_fall      = ~r_clk_s2 & r_clk_s3;
  assign w_byte      = {r_shift_in, r_din_s2};
  assign w_addr_next = r_addr + 7'd1;
  assign w_cmd_rd    = rd_reg(w_byte[6:0], r_bank);
  assign w_next_rd   = rd_reg(w_addr_next, r_bank);
  assign w_wr_hit    = (r_addr != 7'd0) && (32'(r_addr) < NUM_REGS);
  assign reg_q       = {r_bank, ID_VALUE};
  assign o_dbg_state = r_state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_clk_s1 <= 1'b0; r_clk_s2 <= 1'b0; r_clk_s3 <= 1'b0;
      r_cs_s1  <= 1'b1; r_cs_s2  <= 1'b1;
      r_din_s1 <= 1'b0; r_din_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= spi_clk;    r_clk_s2 <= r_clk_s1; r_clk_s3 <= r_clk_s2;
      r_cs_s1  <= spi_cs_b;   r_cs_s2  <= r_cs_s1;
      r_din_s1 <= spi_data_i; r_din_s2 <= r_din_s1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_bcnt      <= 4'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_addr      <= 7'd0;
      r_bank      <= {(NUM_REGS-1){RESET_VALUE}};
      spi_data_o  <= 1'b0;
      spi_data_t  <= 1'b1;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 7'd0;
      busy        <= 1'b0;
    end else begin
      reg_wr_stb <= 1'b0;
      if (r_cs_s2) begin
        // Deselect from any state drops a partial byte and releases the pad.
        r_state    <= IDLE;
        r_bcnt     <= 4'd0;
        spi_data_t <= 1'b1;
        spi_data_o <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= CMD;
            r_bcnt  <= 4'd0;
            busy    <= 1'b1;
          end
          CMD: if (w_rise) begin
            r_shift_in <= w_byte[6:0];
            if (r_bcnt == 4'd7) begin
              r_bcnt <= 4'd0;
              r_addr <= w_byte[6:0];
              if (w_byte[7]) begin
                r_state     <= RD_DATA;
                r_shift_out <= w_cmd_rd;
                spi_data_o  <= w_cmd_rd[7];
                spi_data_t  <= 1'b0;
              end else begin
                r_state <= WR_DATA;
              end
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
          WR_DATA: if (w_rise) begin
            r_shift_in <= w_byte[6:0];
            if (r_bcnt == 4'd7) begin
              r_bcnt <= 4'd0;
              r_addr <= w_addr_next;
              if (w_wr_hit) begin
                reg_wr_stb  <= 1'b1;
                reg_wr_addr <= r_addr;
                for (int i = 1; i < NUM_REGS; i++)
                  if (r_addr == 7'(i)) r_bank[i] <= w_byte;
              end
            end else begin
              r_bcnt <= r_bcnt + 4'd1;
            end
          end
          RD_DATA: begin
            if (w_rise) begin
              if (r_bcnt != 4'd8) r_bcnt <= r_bcnt + 4'd1;
            end else if (w_fall) begin
              // bcnt==0 is the trailing fall of the command byte: keep bit 7 on the pad.
              if (r_bcnt == 4'd8) begin
                r_bcnt      <= 4'd0;
                r_addr      <= w_addr_next;
                r_shift_out <= w_next_rd;
                spi_data_o  <= w_next_rd[7];
              end else if (r_bcnt != 4'd0) begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
                spi_data_o  <= r_shift_out[6];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: acts as the SPI master and scores read bytes against a register model.
module tb_spi_reg_target;

  localparam int         HALF = 60;
  localparam logic [7:0] ID   = 8'hA5;

  logic        aclk, aresetn, spi_clk, spi_cs_b, spi_data_i;
  logic        spi_data_o, spi_data_t, reg_wr_stb, busy;
  logic [63:0] reg_q;
  logic [6:0]  reg_wr_addr;
  logic [1:0]  dbg_state;

  spi_reg_target dut (
    .aclk(aclk), .aresetn(aresetn), .spi_clk(spi_clk), .spi_cs_b(spi_cs_b),
    .spi_data_i(spi_data_i), .spi_data_o(spi_data_o), .spi_data_t(spi_data_t),
    .reg_q(reg_q), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int          n_vec = 0, n_err = 0;
  int          stb_cnt = 0, t_bad = 0;
  logic [6:0]  stb_addr = 7'd0;
  logic [7:0]  model [8];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  always @(negedge aclk) begin
    if (reg_wr_stb === 1'b1) begin
      stb_cnt  = stb_cnt + 1;
      stb_addr = reg_wr_addr;
    end
  end

  function automatic logic [7:0] exp_rd(input logic [6:0] a);
    if (a == 7'd0) return ID;
    if (a < 7'd8)  return model[a[2:0]];
    return 8'h00;
  endfunction

  function automatic logic [63:0] exp_regs();
    logic [63:0] v;
    v[7:0] = ID;
    for (int i = 1; i < 8; i++) v[i*8 +: 8] = model[i];
    return v;
  endfunction

  // driver tasks
  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  task automatic spi_start();
    @(negedge aclk);
    spi_cs_b = 1'b0;
    #HALF;
  endtask

  task automatic spi_stop();
    #HALF;
    spi_cs_b   = 1'b1;
    spi_data_i = 1'b0;
  endtask

  task automatic spi_send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_data_i = b[i];
      #HALF; spi_clk = 1'b1;
      #HALF; spi_clk = 1'b0;
    end
  endtask

  task automatic spi_recv_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_data_i = 1'($urandom_range(0, 1));
      #HALF; spi_clk = 1'b1;
      #HALF;
      b[i] = spi_data_o;
      if (spi_data_t !== 1'b0) t_bad = t_bad + 1;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input int n, input logic [7:0] d [4]);
    logic [6:0] ak;
    spi_start();
    spi_send_byte({1'b0, a});
    for (int k = 0; k < n; k++) begin
      spi_send_byte(d[k]);
      ak = a + 7'(k);
      if (ak >= 7'd1 && ak < 7'd8) model[ak[2:0]] = d[k];
    end
    spi_stop();
    #(4*HALF);
  endtask

  task automatic push_exp(input logic [6:0] a, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_rd(a + 7'(k)));
  endtask

  task automatic spi_read(input logic [6:0] a, input int n);
    logic [7:0] b;
    spi_start();
    spi_send_byte({1'b1, a});
    for (int k = 0; k < n; k++) begin
      spi_recv_byte(b);
      got_q.push_back(b);
    end
    spi_stop();
  endtask

  // tests
  task automatic test_reset();
    aresetn = 1'b0; spi_clk = 1'b0; spi_cs_b = 1'b1; spi_data_i = 1'b0;
    model_reset();
    #23;
    n_vec++; if (spi_data_t !== 1'b1 || spi_data_o !== 1'b0) begin n_err++;
      $display("FAIL reset_pad got t=%b o=%b want t=1 o=0", spi_data_t, spi_data_o); end
    n_vec++; if (reg_wr_stb !== 1'b0 || reg_wr_addr !== 7'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL reset_ctl got stb=%b addr=%h busy=%b want 0/00/0", reg_wr_stb, reg_wr_addr, busy); end
    n_vec++; if (reg_q !== exp_regs() || dbg_state !== 2'd0) begin n_err++;
      $display("FAIL reset_regs got %h st=%0d want %h st=0", reg_q, dbg_state, exp_regs()); end
    #20 aresetn = 1'b1;
    #40;
  endtask

  task automatic test_read_id();
    logic [7:0] got;
    t_bad = 0;
    push_exp(7'd0, 1);
    spi_start();
    spi_send_byte(8'h80);
    spi_recv_byte(got);
    got_q.push_back(got);
    n_vec++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL busy_active got %b want 1", busy); end
    spi_stop();
    #30;
    n_vec++; if (spi_data_t !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL cs_release got t=%b busy=%b want t=1 busy=0", spi_data_t, busy); end
    n_vec++; if (t_bad !== 0) begin n_err++;
      $display("FAIL rd_tristate got %0d undriven bits want 0", t_bad); end
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL read_id got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    #(4*HALF);
  endtask

  task automatic test_write();
    logic [7:0] d [4] = '{8'h5C, 8'h00, 8'h00, 8'h00};
    logic [7:0] got;
    int s0 = stb_cnt;
    spi_write(7'd3, 1, d);
    n_vec++; if (stb_cnt !== s0 + 1 || stb_addr !== 7'd3) begin n_err++;
      $display("FAIL wr_strobe got cnt=%0d addr=%h want cnt=%0d addr=03", stb_cnt - s0, stb_addr, 1); end
    n_vec++; if (reg_q[31:24] !== 8'h5C) begin n_err++;
      $display("FAIL wr_reg3 got %h want 5c", reg_q[31:24]); end
    push_exp(7'd3, 1);
    spi_read(7'd3, 1);
    #(4*HALF);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL readback3 got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_burst();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
    logic [7:0] got;
    int s0 = stb_cnt;
    spi_write(7'd5, 3, d);
    n_vec++; if (stb_cnt !== s0 + 3 || stb_addr !== 7'd7) begin n_err++;
      $display("FAIL burst_strobe got cnt=%0d addr=%h want cnt=3 addr=07", stb_cnt - s0, stb_addr); end
    push_exp(7'd5, 4);
    spi_read(7'd5, 4);
    #(4*HALF);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL burst_read got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_discard();
    logic [7:0] d0 [4]  = '{8'h77, 8'h00, 8'h00, 8'h00};
    logic [7:0] d40 [4] = '{8'h99, 8'h00, 8'h00, 8'h00};
    logic [7:0] got;
    int s0 = stb_cnt;
    spi_write(7'd0, 1, d0);
    spi_write(7'h40, 1, d40);
    n_vec++; if (stb_cnt !== s0) begin n_err++;
      $display("FAIL discard_strobe got %0d pulses want 0", stb_cnt - s0); end
    n_vec++; if (reg_q !== exp_regs()) begin n_err++;
      $display("FAIL discard_regs got %h want %h", reg_q, exp_regs()); end
    push_exp(7'd0, 1);
    spi_read(7'd0, 1);
    #(4*HALF);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL discard_id got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_abort();
    logic [7:0] d [4] = '{8'h3C, 8'h00, 8'h00, 8'h00};
    int s0 = stb_cnt;
    spi_start();
    spi_send_byte(8'h02);
    for (int i = 0; i < 4; i++) begin
      spi_data_i = 1'b1;
      #HALF; spi_clk = 1'b1;
      #HALF; spi_clk = 1'b0;
    end
    spi_stop();
    #(4*HALF);
    n_vec++; if (stb_cnt !== s0 || reg_q[23:16] !== model[2]) begin n_err++;
      $display("FAIL abort got pulses=%0d reg2=%h want 0/%h", stb_cnt - s0, reg_q[23:16], model[2]); end
    spi_write(7'd2, 1, d);
    n_vec++; if (stb_cnt !== s0 + 1 || reg_q[23:16] !== 8'h3C) begin n_err++;
      $display("FAIL after_abort got pulses=%0d reg2=%h want 1/3c", stb_cnt - s0, reg_q[23:16]); end
  endtask

  task automatic test_cs_pulse();
    int s0 = stb_cnt;
    @(negedge aclk);
    spi_cs_b = 1'b0;
    repeat (5) @(negedge aclk);
    spi_cs_b = 1'b1;
    #100;
    n_vec++; if (stb_cnt !== s0 || reg_q !== exp_regs() || dbg_state !== 2'd0) begin n_err++;
      $display("FAIL cs_pulse got pulses=%0d regs=%h st=%0d want 0/%h/0",
               stb_cnt - s0, reg_q, dbg_state, exp_regs()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [4];
    logic [7:0] got;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
      spi_write(7'($urandom_range(1, 7)), $urandom_range(1, 4), d);
    end
    n_vec++; if (reg_q !== exp_regs()) begin n_err++;
      $display("FAIL b2b_regs got %h want %h", reg_q, exp_regs()); end
    push_exp(7'd0, 8);
    spi_read(7'd0, 8);
    #(4*HALF);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL b2b_read got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    spi_start();
    spi_send_byte(8'h83);
    for (int i = 0; i < 3; i++) begin
      #HALF; spi_clk = 1'b1;
      #HALF; spi_clk = 1'b0;
    end
    n_vec++; if (spi_data_t !== 1'b0) begin n_err++;
      $display("FAIL pre_reset_drive got t=%b want 0", spi_data_t); end
    #33;
    aresetn = 1'b0;
    #1;
    model_reset();
    n_vec++; if (spi_data_t !== 1'b1 || reg_q !== exp_regs()) begin n_err++;
      $display("FAIL async_reset got t=%b regs=%h want 1/%h", spi_data_t, reg_q, exp_regs()); end
    spi_cs_b = 1'b1; spi_data_i = 1'b0;
    #17 aresetn = 1'b1;
    #60;
    push_exp(7'd0, 1);
    push_exp(7'd3, 1);
    spi_read(7'd0, 1);
    #(4*HALF);
    spi_read(7'd3, 1);
    #(4*HALF);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      n_vec++; if (got !== exp_q[0]) begin n_err++;
        $display("FAIL post_reset_read got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write();
    test_burst();
    test_discard();
    test_abort();
    test_cs_pulse();
    test_back_to_back();
    test_async_reset();
    n_vec++; if (exp_q.size() !== 0) begin n_err++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
